// File: rtl/ss_display_arb.sv
// ---------------------------------------------------------------------------
// ss_display_arb
// Two-requester arbiter for a shared 8-digit seven-segment display. The
// owner's digits and decimal points are registered onto the decoder bus.
// An owner keeps the display for at least HOLD_CYCLES cycles while the other
// side is also requesting. After that the display passes round-robin.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   req_a/b     requester A/B wants the display
//   digits_a/b  8 x 4-bit hex nibbles, nibble i = display position i
//   flt_pt_a/b  decimal-point bits, bit i = position i
//   gnt_a/b     registered ownership flags (never both high)
//   digits_out  registered digits to the decoder
//   flt_pt_out  registered decimal points to the decoder
// ---------------------------------------------------------------------------
module ss_display_arb #(
  parameter int HOLD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_a,
  input  logic [31:0] digits_a,
  input  logic [7:0]  flt_pt_a,
  input  logic        req_b,
  input  logic [31:0] digits_b,
  input  logic [7:0]  flt_pt_b,
  output logic        gnt_a,
  output logic        gnt_b,
  output logic [31:0] digits_out,
  output logic [7:0]  flt_pt_out
);

  // A one-cycle tenure still needs a 1-bit counter (it just stays at zero).
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] hold_cnt, hold_cnt_next;
  logic          hold_expired;
  logic          gnt_a_reg, gnt_b_reg;
  logic [31:0]   digits_reg;
  logic [7:0]    flt_pt_reg;

  assign hold_expired = (hold_cnt == HOLD_MAX);

  // Next-state and tenure counter
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt;

    case (state_reg)
      IDLE: begin
        // A wins a simultaneous request
        if (req_a)      state_next = OWN_A;
        else if (req_b) state_next = OWN_B;
      end
      OWN_A: begin
        // Voluntary release ignores tenure; preemption needs it expired
        if (!req_a)                    state_next = req_b ? OWN_B : IDLE;
        else if (req_b && hold_expired) state_next = OWN_B;
      end
      OWN_B: begin
        if (!req_b)                    state_next = req_a ? OWN_A : IDLE;
        else if (req_a && hold_expired) state_next = OWN_A;
      end
      default: state_next = IDLE;
    endcase

    // Any grant entry or hand-over starts a fresh tenure; an unchanged
    // owner counts up and saturates so "expired" stays asserted.
    if (state_next != state_reg || state_next == IDLE) begin
      hold_cnt_next = '0;
    end else if (!hold_expired) begin
      hold_cnt_next = hold_cnt + CW'(1);
    end
  end

  // State, grants and display data are all registered from state_next so
  // the data bus changes on the same edge as the grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      hold_cnt   <= '0;
      gnt_a_reg  <= 1'b0;
      gnt_b_reg  <= 1'b0;
      digits_reg <= 32'h0;
      flt_pt_reg <= 8'h00;
    end else begin
      state_reg <= state_next;
      hold_cnt  <= hold_cnt_next;
      gnt_a_reg <= (state_next == OWN_A);
      gnt_b_reg <= (state_next == OWN_B);
      case (state_next)
        OWN_A: begin
          digits_reg <= digits_a;
          flt_pt_reg <= flt_pt_a;
        end
        OWN_B: begin
          digits_reg <= digits_b;
          flt_pt_reg <= flt_pt_b;
        end
        default: ; // idle: keep showing the last owner's value
      endcase
    end
  end

  assign gnt_a      = gnt_a_reg;
  assign gnt_b      = gnt_b_reg;
  assign digits_out = digits_reg;
  assign flt_pt_out = flt_pt_reg;

endmodule

// File: tb/tb_ss_display_arb.sv
// ---------------------------------------------------------------------------
// tb_ss_display_arb
// Scoreboard bench for ss_display_arb with HOLD_CYCLES=4, plus a second
// instance with HOLD_CYCLES=1 to observe per-cycle alternation.
// ---------------------------------------------------------------------------
module tb_ss_display_arb;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic [31:0] digits_a = '0, digits_b = '0;
  logic [7:0]  flt_pt_a = '0, flt_pt_b = '0;
  logic        gnt_a, gnt_b;
  logic [31:0] digits_out;
  logic [7:0]  flt_pt_out;
  logic        gnt_a1, gnt_b1;
  logic [31:0] digits_out1;
  logic [7:0]  flt_pt_out1;

  always #5 clk = ~clk;

  ss_display_arb #(.HOLD_CYCLES(H)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .digits_a(digits_a), .flt_pt_a(flt_pt_a),
    .req_b(req_b), .digits_b(digits_b), .flt_pt_b(flt_pt_b),
    .gnt_a(gnt_a), .gnt_b(gnt_b),
    .digits_out(digits_out), .flt_pt_out(flt_pt_out)
  );

  ss_display_arb #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_a(req_a), .digits_a(digits_a), .flt_pt_a(flt_pt_a),
    .req_b(req_b), .digits_b(digits_b), .flt_pt_b(flt_pt_b),
    .gnt_a(gnt_a1), .gnt_b(gnt_b1),
    .digits_out(digits_out1), .flt_pt_out(flt_pt_out1)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_txn   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: owner 0=none, 1=A, 2=B; tenure = cycles already owned
  typedef struct {
    string       tag;
    logic        ga;
    logic        gb;
    logic [31:0] d;
    logic [7:0]  f;
  } exp_t;

  exp_t        sbq[$];
  int          m_owner;
  int          m_ten;
  logic [31:0] m_d;
  logic [7:0]  m_f;

  task automatic model_reset();
    m_owner = 0;
    m_ten   = 0;
    m_d     = 32'h0;
    m_f     = 8'h00;
  endtask

  task automatic push_expect(input string tag);
    int   nxt;
    exp_t e;
    nxt = m_owner;
    case (m_owner)
      0: nxt = req_a ? 1 : (req_b ? 2 : 0);
      1: begin
        if (!req_a)                     nxt = req_b ? 2 : 0;
        else if (req_b && m_ten >= H-1) nxt = 2;
      end
      default: begin
        if (!req_b)                     nxt = req_a ? 1 : 0;
        else if (req_a && m_ten >= H-1) nxt = 1;
      end
    endcase
    if (nxt != 0 && nxt == m_owner) m_ten++;
    else                            m_ten = 0;
    if (nxt == 1) begin m_d = digits_a; m_f = flt_pt_a; end
    if (nxt == 2) begin m_d = digits_b; m_f = flt_pt_b; end
    m_owner = nxt;
    e.tag = tag;
    e.ga  = (nxt == 1);
    e.gb  = (nxt == 2);
    e.d   = m_d;
    e.f   = m_f;
    sbq.push_back(e);
  endtask

  // Drive current inputs through one clock edge and score the result
  task automatic step(input string tag);
    exp_t e;
    push_expect(tag);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    n_txn++;
    $display("[TB] txn %0d %s ra=%0b rb=%0b ga=%0b gb=%0b d=%08h f=%02h", n_txn, e.tag,
             req_a, req_b, gnt_a, gnt_b, digits_out, flt_pt_out);
    chk({e.tag, "_gnt_a"}, 64'(gnt_a), 64'(e.ga));
    chk({e.tag, "_gnt_b"}, 64'(gnt_b), 64'(e.gb));
    chk({e.tag, "_digits"}, 64'(digits_out), 64'(e.d));
    chk({e.tag, "_flt"}, 64'(flt_pt_out), 64'(e.f));
    chk({e.tag, "_excl"}, 64'(gnt_a & gnt_b), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    model_reset();

    // Asynchronous reset with both requesting, before any clock edge
    #2;
    req_a = 1'b1;
    req_b = 1'b1;
    rst   = 1'b1;
    #1;
    chk("rst_gnt_a", 64'(gnt_a), 64'(0));
    chk("rst_gnt_b", 64'(gnt_b), 64'(0));
    chk("rst_digits", 64'(digits_out), 64'(0));
    chk("rst_flt", 64'(flt_pt_out), 64'(0));
    chk("rst_gnt_a1", 64'(gnt_a1), 64'(0));

    @(negedge clk);
    rst      = 1'b0;
    model_reset();
    digits_a = 32'h12345678;
    digits_b = 32'hDEADBEEF;
    flt_pt_a = 8'h5A;
    flt_pt_b = 8'hA5;

    // Tie from IDLE then round-robin preemption every H cycles
    for (int k = 1; k <= 16; k++) begin
      step("both");
      chk("h1_alt_a", 64'(gnt_a1), 64'(k % 2));
      chk("h1_alt_b", 64'(gnt_b1), 64'((k + 1) % 2));
      if (k == 1) chk("tie_digits", 64'(digits_out), 64'h12345678);
      if (k == 2) chk("h1_digits", 64'(digits_out1), 64'hDEADBEEF);
      if (k == 2) chk("h1_flt", 64'(flt_pt_out1), 64'hA5);
      if (k == 4) chk("pre_still_a", 64'(gnt_a), 64'(1));
      if (k == 5) chk("pre_gnt_b", 64'(gnt_b), 64'(1));
      if (k == 5) chk("pre_digits_b", 64'(digits_out), 64'hDEADBEEF);
      if (k == 9) chk("pre_back_a", 64'(gnt_a), 64'(1));
    end

    // Early release: A at tenure 1 drops, B takes over with a fresh tenure
    req_a = 1'b0; req_b = 1'b0;
    step("idle");
    req_a = 1'b1;
    step("own_a0");
    step("own_a1");
    chk("early_cnt1", 64'(dut.hold_cnt), 64'(1));
    req_a = 1'b0; req_b = 1'b1;
    step("early");
    chk("early_gnt_b", 64'(gnt_b), 64'(1));
    chk("early_cnt0", 64'(dut.hold_cnt), 64'(0));

    // Release to IDLE: display holds the last owner's data
    req_b    = 1'b0;
    digits_b = 32'hCAFEF00D;
    step("rel");
    chk("rel_hold", 64'(digits_out), 64'hDEADBEEF);
    step("rel2");
    chk("rel_hold2", 64'(digits_out), 64'hDEADBEEF);

    // Mid-grant reset at tenure 2
    req_a = 1'b1;
    step("mg0");
    step("mg1");
    step("mg2");
    chk("mg_cnt2", 64'(dut.hold_cnt), 64'(2));
    #1 rst = 1'b1;
    #1;
    chk("mg_gnt_a", 64'(gnt_a), 64'(0));
    chk("mg_digits", 64'(digits_out), 64'(0));
    chk("mg_flt", 64'(flt_pt_out), 64'(0));
    chk("mg_cnt", 64'(dut.hold_cnt), 64'(0));
    #1;
    rst   = 1'b0;
    req_a = 1'b0;
    req_b = 1'b1;
    model_reset();
    step("post_rst");
    chk("post_rst_gnt_b", 64'(gnt_b), 64'(1));
    chk("post_rst_digits", 64'(digits_out), 64'hCAFEF00D);

    // Random traffic against the model
    for (int i = 0; i < 200; i++) begin
      req_a    = ($urandom_range(0, 3) != 0);
      req_b    = ($urandom_range(0, 3) != 0);
      digits_a = $urandom();
      digits_b = $urandom();
      flt_pt_a = 8'($urandom_range(0, 255));
      flt_pt_b = 8'($urandom_range(0, 255));
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
